// File: rtl/sc_mmio_ctrl_if.sv
// CPU data-bus slice seen by the MMIO controller.
//   addr/wdata/we : CPU -> controller (byte address, store data, store strobe)
//   sel/rdata     : controller -> CPU (address hit and read data, both combinational)
interface sc_mmio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        sel;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input sel, input rdata);
  modport slave  (input addr, input wdata, input we, output sel, output rdata);
endinterface

// File: rtl/sc_mmio_ctrl.sv
// Memory-mapped I/O controller: switches, debounced keys with sticky press
// capture, LEDs, 7-segment digits, periodic timer and one interrupt line.
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : CPU data-bus slave port (addr, wdata, we -> sel, rdata)
//   sw           : raw switch inputs
//   key          : raw key inputs, active-low
//   led          : LED register
//   hex          : digit i on hex[7i+6:7i], gfedcba, active-low
//   irq          : registered interrupt request
module sc_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int unsigned NUM_SW     = 10,
  parameter int unsigned NUM_KEY    = 3,
  parameter int unsigned NUM_LED    = 10,
  parameter int unsigned NUM_HEX    = 6,
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  sc_mmio_ctrl_if.slave        bus,
  input  logic [NUM_SW-1:0]    sw,
  input  logic [NUM_KEY-1:0]   key,
  output logic [NUM_LED-1:0]   led,
  output logic [7*NUM_HEX-1:0] hex,
  output logic                 irq
);

  localparam logic [5:0] IDX_SW     = 6'd0;
  localparam logic [5:0] IDX_KEYLVL = 6'd1;
  localparam logic [5:0] IDX_KEYEDG = 6'd2;
  localparam logic [5:0] IDX_LED    = 6'd3;
  localparam logic [5:0] IDX_TCOUNT = 6'd16;
  localparam logic [5:0] IDX_TCMP   = 6'd17;
  localparam logic [5:0] IDX_TSTAT  = 6'd18;
  localparam logic [5:0] IDX_CTRL   = 6'd19;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [NUM_SW-1:0]             sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [NUM_KEY-1:0]            key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [NUM_KEY-1:0]            key_lvl_q, key_lvl_d;
  logic [NUM_KEY-1:0]            key_edge_q, key_edge_d;
  logic [NUM_KEY-1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_LED-1:0]            led_q, led_d;
  logic [NUM_HEX-1:0][4:0]       hex_q, hex_d;
  logic [31:0]                   tcount_q, tcount_d;
  logic [31:0]                   tcmp_q, tcmp_d;
  logic                          tstat_q, tstat_d;
  logic [1:0]                    ctrl_q, ctrl_d;
  logic                          irq_q, irq_d;

  logic                          hit_c, wr_c, tmatch_c;
  logic [5:0]                    widx_c;
  logic [NUM_KEY-1:0]            key_pr_c, key_press_c, key_clr_c;
  logic [31:0]                   rdata_c;
  logic                          unused_addr_lsb;

  // 7-segment decode, gfedcba active-low; bit4 blanks the digit
  function automatic logic [6:0] seg7(input logic [4:0] v);
    logic [6:0] s;
    if (v[4]) begin
      s = 7'h7F;
    end else begin
      case (v[3:0])
        4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
        4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
        4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
        4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  // Address decode; byte lane bits are don't-care
  assign hit_c           = (bus.addr[31:8] == BASE_ADDR[31:8]);
  assign widx_c          = bus.addr[7:2];
  assign wr_c            = hit_c & bus.we;
  assign unused_addr_lsb = ^bus.addr[1:0];
  assign key_pr_c        = ~key_s2_q;
  assign tmatch_c        = (tcmp_q != 32'd0) && (tcount_q == tcmp_q);

  // Read mux
  always_comb begin
    rdata_c = '0;
    if (hit_c) begin
      case (widx_c)
        IDX_SW:     rdata_c = 32'(sw_s2_q);
        IDX_KEYLVL: rdata_c = 32'(key_lvl_q);
        IDX_KEYEDG: rdata_c = 32'(key_edge_q);
        IDX_LED:    rdata_c = 32'(led_q);
        IDX_TCOUNT: rdata_c = tcount_q;
        IDX_TCMP:   rdata_c = tcmp_q;
        IDX_TSTAT:  rdata_c = {31'd0, tstat_q};
        IDX_CTRL:   rdata_c = {30'd0, ctrl_q};
        default: begin
          for (int i = 0; i < int'(NUM_HEX); i++) begin
            if (widx_c == 6'(4 + i)) rdata_c = 32'(hex_q[i]);
          end
        end
      endcase
    end
  end

  assign bus.sel   = hit_c;
  assign bus.rdata = rdata_c;

  // Next-state logic for all registers
  always_comb begin
    sw_s1_d     = sw;
    sw_s2_d     = sw_s1_q;
    key_s1_d    = key;
    key_s2_d    = key_s1_q;
    key_lvl_d   = key_lvl_q;
    deb_cnt_d   = deb_cnt_q;
    key_press_c = '0;
    led_d       = led_q;
    hex_d       = hex_q;
    tcmp_d      = tcmp_q;
    ctrl_d      = ctrl_q;

    // Debounce: count consecutive cycles the synced key differs from the accepted level
    for (int k = 0; k < int'(NUM_KEY); k++) begin
      if (key_pr_c[k] != key_lvl_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          key_lvl_d[k]   = key_pr_c[k];
          deb_cnt_d[k]   = '0;
          key_press_c[k] = key_pr_c[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
        end
      end else begin
        deb_cnt_d[k] = '0;
      end
    end

    // Sticky press capture; a new press wins over a simultaneous clear
    key_clr_c  = (wr_c && widx_c == IDX_KEYEDG) ? bus.wdata[NUM_KEY-1:0] : '0;
    key_edge_d = (key_edge_q & ~key_clr_c) | key_press_c;

    if (wr_c && widx_c == IDX_LED)  led_d  = bus.wdata[NUM_LED-1:0];
    if (wr_c && widx_c == IDX_CTRL) ctrl_d = bus.wdata[1:0];
    for (int i = 0; i < int'(NUM_HEX); i++) begin
      if (wr_c && widx_c == 6'(4 + i)) hex_d[i] = bus.wdata[4:0];
    end

    // Timer: match restarts the count; a compare write restarts it too
    tcount_d = tmatch_c ? 32'd0 : tcount_q + 32'd1;
    if (wr_c && widx_c == IDX_TCMP) begin
      tcmp_d   = bus.wdata;
      tcount_d = 32'd0;
    end
    tstat_d = (tstat_q & ~(wr_c && widx_c == IDX_TSTAT && bus.wdata[0])) | tmatch_c;

    irq_d = (ctrl_q[0] & tstat_q) | (ctrl_q[1] & (|key_edge_q));
  end

  // State registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_lvl_q  <= '0;
      key_edge_q <= '0;
      deb_cnt_q  <= '0;
      led_q      <= '0;
      hex_q      <= {NUM_HEX{5'h10}};
      tcount_q   <= '0;
      tcmp_q     <= '0;
      tstat_q    <= 1'b0;
      ctrl_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_lvl_q  <= key_lvl_d;
      key_edge_q <= key_edge_d;
      deb_cnt_q  <= deb_cnt_d;
      led_q      <= led_d;
      hex_q      <= hex_d;
      tcount_q   <= tcount_d;
      tcmp_q     <= tcmp_d;
      tstat_q    <= tstat_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  // Outputs
  assign led = led_q;
  assign irq = irq_q;
  always_comb begin
    hex = '0;
    for (int i = 0; i < int'(NUM_HEX); i++) hex[7*i +: 7] = seg7(hex_q[i]);
  end

endmodule

// File: tb/tb_sc_mmio_ctrl.sv
// Scoreboard bench for sc_mmio_ctrl with a cycle-stepped behavioural model.
module tb_sc_mmio_ctrl;

  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam int DEB  = 4;
  localparam logic [31:0] MASK = 32'((1 << DEB) - 1);

  logic        clock, reset;
  logic [9:0]  sw;
  logic [2:0]  key;
  logic [9:0]  led;
  logic [41:0] hex;
  logic        irq;

  sc_mmio_ctrl_if bus();

  sc_mmio_ctrl #(
    .BASE_ADDR(BASE), .NUM_SW(10), .NUM_KEY(3), .NUM_LED(10), .NUM_HEX(6),
    .DEB_W(16), .DEB_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .sw(sw), .key(key), .led(led), .hex(hex), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors;
  int miscompares;

  typedef struct { logic [31:0] rdata; logic sel; } exp_t;
  exp_t sb_q[$];
  logic rd_valid;

  // Reference model state
  logic [9:0]  m_sw1, m_sw2, m_led;
  logic [2:0]  m_k1, m_k2, m_lvl, m_edge;
  logic [31:0] m_hist [3];
  logic [4:0]  m_hex [6];
  logic [31:0] m_tcount, m_tcmp;
  logic        m_tstat, m_irq;
  logic [1:0]  m_ctrl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input logic [4:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return v[4] ? 7'h7F : tbl[v[3:0]];
  endfunction

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_k1 = '1; m_k2 = '1; m_lvl = '0; m_edge = '0;
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
    m_led = '0;
    for (int i = 0; i < 6; i++) m_hex[i] = 5'h10;
    m_tcount = '0; m_tcmp = '0; m_tstat = 1'b0; m_ctrl = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic w, match, n_irq;
    logic [5:0] idx;
    logic [2:0] press, clr;
    w     = (bus.addr[31:8] == BASE[31:8]) && bus.we;
    idx   = bus.addr[7:2];
    n_irq = (m_ctrl[0] && m_tstat) || (m_ctrl[1] && (m_edge != 3'd0));
    // a level is accepted once the last DEB synced samples all disagree with it
    press = '0;
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = {m_hist[k][30:0], ~m_k2[k]};
      if ((m_hist[k] & MASK) == (m_lvl[k] ? 32'd0 : MASK)) begin
        m_lvl[k] = ~m_lvl[k];
        press[k] = m_lvl[k];
      end
    end
    clr    = (w && idx == 6'd2) ? bus.wdata[2:0] : 3'd0;
    m_edge = (m_edge & ~clr) | press;
    m_k2 = m_k1; m_k1 = key; m_sw2 = m_sw1; m_sw1 = sw;
    match = (m_tcmp != 32'd0) && (m_tcount == m_tcmp);
    if (w && idx == 6'd17) begin m_tcount = 32'd0; m_tcmp = bus.wdata; end
    else if (match)            m_tcount = 32'd0;
    else                       m_tcount = m_tcount + 32'd1;
    m_tstat = (m_tstat && !(w && idx == 6'd18 && bus.wdata[0])) || match;
    if (w && idx == 6'd3)  m_led  = bus.wdata[9:0];
    if (w && idx == 6'd19) m_ctrl = bus.wdata[1:0];
    for (int i = 0; i < 6; i++) if (w && idx == 6'(4 + i)) m_hex[i] = bus.wdata[4:0];
    m_irq = n_irq;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [5:0] idx;
    logic [31:0] r;
    idx = a[7:2];
    r = '0;
    if (a[31:8] == BASE[31:8]) begin
      case (idx)
        6'd0:  r = 32'(m_sw2);
        6'd1:  r = 32'(m_lvl);
        6'd2:  r = 32'(m_edge);
        6'd3:  r = 32'(m_led);
        6'd16: r = m_tcount;
        6'd17: r = m_tcmp;
        6'd18: r = {31'd0, m_tstat};
        6'd19: r = {30'd0, m_ctrl};
        default: for (int i = 0; i < 6; i++) if (idx == 6'(4 + i)) r = 32'(m_hex[i]);
      endcase
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Monitor: outputs every cycle, read data whenever a read is presented
  initial begin
    logic [41:0] eh;
    exp_t e;
    forever begin
      @(negedge clock);
      eh = '0;
      for (int i = 0; i < 6; i++) eh[7*i +: 7] = seg(m_hex[i]);
      check("led", 64'(led), 64'(m_led));
      check("hex", 64'(hex), 64'(eh));
      check("irq", 64'(irq), 64'(m_irq));
      if (rd_valid) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sb_empty: read presented with no expectation at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("rdata", 64'(bus.rdata), 64'(e.rdata));
          check("sel", 64'(bus.sel), 64'(e.sel));
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rd);
    exp_t e;
    @(posedge clock); #1;
    bus.addr = a; bus.wdata = d; bus.we = w; rd_valid = rd;
    if (rd) begin
      e.rdata = model_read(a);
      e.sel   = (a[31:8] == BASE[31:8]);
      sb_q.push_back(e);
    end
  endtask

  task automatic rd(input logic [7:0] off);
    drive(1'b0, BASE | 32'(off), 32'd0, 1'b1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    drive(1'b1, BASE | 32'(off), d, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; sw = '0; key = '1; rd_valid = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
    #12 reset = 1'b0;

    // Reset values of every mapped register
    for (int o = 0; o < 20; o++) rd(8'(o * 4));

    // LED/HEX writes, then asynchronous reset between edges
    wr(8'h0C, 32'h3FF);
    wr(8'h10, 32'h5);
    idle();
    check("pre_rst_led", 64'(led), 64'h3FF);
    check("pre_rst_hex0", 64'(hex[6:0]), 64'h12);
    #2 reset = 1'b1;
    #1;
    check("async_rst_led", 64'(led), 64'h0);
    check("async_rst_hex", 64'(hex), 64'h3FF_FFFF_FFFF);
    #2 reset = 1'b0;

    // Switch synchroniser latency
    rd(8'h00); sw = 10'h2A5;
    repeat (3) rd(8'h00);

    // Debounce: short bounce rejected, long press accepted once
    rd(8'h08); key[0] = 1'b0;
    repeat (3) rd(8'h08);
    key[0] = 1'b1;
    repeat (2) rd(8'h08);
    key[0] = 1'b0;
    repeat (10) rd(8'h08);
    rd(8'h04);
    wr(8'h08, 32'h1);
    rd(8'h08);

    // Release, then an accepted press on the same edge as its W1C
    key[0] = 1'b1;
    repeat (8) rd(8'h04);
    wr(8'h4C, 32'h2);
    key[0] = 1'b0;
    repeat (4) idle();
    wr(8'h08, 32'h1);
    rd(8'h08);
    check("edge_beats_w1c", 64'(bus.rdata[0]), 64'h1);
    repeat (2) rd(8'h08);

    // Periodic timer with interrupt
    wr(8'h08, 32'h7);
    wr(8'h4C, 32'h1);
    wr(8'h44, 32'd9);
    for (int c = 0; c < 24; c++) rd((c % 2 == 0) ? 8'h40 : 8'h48);
    wr(8'h48, 32'h1);
    repeat (4) rd(8'h48);

    // Unmapped offsets and out-of-range addresses
    rd(8'h80); rd(8'h50);
    wr(8'h80, 32'hFFFF_FFFF);
    drive(1'b1, 32'hD000_000C, 32'h155, 1'b0);
    drive(1'b1, 32'h4000_0044, 32'h3, 1'b0);
    drive(1'b0, 32'hD000_000C, 32'd0, 1'b1);
    drive(1'b0, 32'hC000_0100, 32'd0, 1'b1);
    rd(8'h0C); rd(8'h44);

    // Randomised traffic with bouncing keys and changing switches
    for (int c = 0; c < 1500; c++) begin
      int op;
      logic [31:0] a, d;
      op = int'($urandom_range(0, 9));
      a  = BASE | 32'($urandom_range(0, 35) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      d = $urandom;
      if (a[7:2] == 6'd17) d = 32'($urandom_range(0, 20));
      if (op < 4)      drive(1'b0, a, 32'd0, 1'b1);
      else if (op < 7) drive(1'b1, a, d, op == 6);
      else             idle();
      if ($urandom_range(0, 9) == 0) sw = 10'($urandom);
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 11) == 0) key[k] = ~key[k];
    end

    repeat (3) idle();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
